// File: rtl/pipe_reg_checkpoint.sv
// pipe_reg_checkpoint: cycle-counted checkpoint that scans an expected register-file table (PC_CHECK_EN adds a PC compare).
// Latency: done rises NUM_CHECKS cycles after the checkpoint edge; no backpressure, start ignored while busy.
module pipe_reg_checkpoint #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_CHECKS = 8,
  parameter int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  parameter int CYC_W      = 32,
  localparam int MCNT_W    = $clog2(NUM_CHECKS + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CYC_W-1:0]  check_cycle,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic              exp_valid,
  input  logic [ADDR_W-1:0] exp_reg,
  input  logic [DATA_W-1:0] exp_val,
`ifdef PC_CHECK_EN
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] exp_pc,
`endif
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [CYC_W-1:0]  cycle,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MCNT_W-1:0] mismatch_cnt,
  output logic [IDX_W:0]    fail_idx,
  output logic [DATA_W-1:0] fail_data
);

  localparam int TBL_D = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rnum;
    logic [DATA_W-1:0] val;
  } entry_t;

  state_t            state, state_nxt;
  logic [CYC_W-1:0]  checkpoint;
  logic [IDX_W-1:0]  scan_idx;
  logic [TBL_D-1:0]  tbl_vld;
  entry_t            tbl [TBL_D];

  logic launch;
  logic tbl_wr;
  logic scan_last;
  logic ent_miss;
  logic pc_miss;

  assign scan_last = (scan_idx == IDX_W'(NUM_CHECKS - 1));
  assign ent_miss  = (state == SCAN) && tbl_vld[scan_idx] && (rf_rdata != tbl[scan_idx].val);

`ifdef PC_CHECK_EN
  logic [DATA_W-1:0] exp_pc_q;
  assign pc_miss = (state == SCAN) && (scan_idx == '0) && (pc != exp_pc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_pc_q <= '0;
    end else if (launch) begin
      exp_pc_q <= exp_pc;
    end
  end
`else
  assign pc_miss = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    tbl_wr    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    rf_raddr  = '0;
    case (state)
      IDLE, DONE: begin
        tbl_wr = exp_we;
        done   = (state == DONE);
        pass   = (state == DONE) && (mismatch_cnt == '0);
        if (start) begin
          state_nxt = COUNT;
          launch    = 1'b1;
        end
      end
      COUNT: begin
        busy = 1'b1;
        if (cycle == checkpoint) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        // Invalid entries present address 0 so stale table contents never leak out.
        if (tbl_vld[scan_idx]) begin
          rf_raddr = tbl[scan_idx].rnum;
        end
        if (scan_last) begin
          state_nxt = DONE;
        end
      end
    endcase
  end

  // Table payload carries no reset; only the valid bits need clearing.
  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      tbl[exp_idx] <= '{rnum: exp_reg, val: exp_val};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle        <= '0;
      checkpoint   <= '0;
      scan_idx     <= '0;
      tbl_vld      <= '0;
      mismatch_cnt <= '0;
      fail_idx     <= '0;
      fail_data    <= '0;
    end else begin
      if (tbl_wr) begin
        tbl_vld[exp_idx] <= exp_valid;
      end
      if (launch) begin
        cycle        <= CYC_W'(1);
        checkpoint   <= (check_cycle == '0) ? CYC_W'(1) : check_cycle;
        scan_idx     <= '0;
        mismatch_cnt <= '0;
        fail_idx     <= '0;
        fail_data    <= '0;
      end
      if (state == COUNT) begin
        if (cycle == checkpoint) begin
          scan_idx <= '0;
        end else begin
          cycle <= cycle + CYC_W'(1);
        end
      end
      if (state == SCAN) begin
        scan_idx     <= scan_idx + IDX_W'(1);
        mismatch_cnt <= mismatch_cnt + MCNT_W'(ent_miss) + MCNT_W'(pc_miss);
        // The PC compare shares the first scan edge with entry 0 and takes precedence.
        if (mismatch_cnt == '0) begin
          if (pc_miss) begin
            fail_idx  <= (IDX_W + 1)'(NUM_CHECKS);
`ifdef PC_CHECK_EN
            fail_data <= pc;
`endif
          end else if (ent_miss) begin
            fail_idx  <= {1'b0, scan_idx};
            fail_data <= rf_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_checkpoint.sv
// Directed bench for pipe_reg_checkpoint with a combinational register-file model.
module tb_pipe_reg_checkpoint;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] check_cycle = '0;
  logic        exp_we = 1'b0;
  logic [2:0]  exp_idx = '0;
  logic        exp_valid = 1'b0;
  logic [4:0]  exp_reg = '0;
  logic [31:0] exp_val = '0;
  logic [31:0] pc = '0;
  logic [31:0] exp_pc = '0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] cycle;
  logic        busy, done, pass;
  logic [3:0]  mismatch_cnt;
  logic [3:0]  fail_idx;
  logic [31:0] fail_data;

  logic [31:0] rf [32];
  logic [4:0]  seq [8];
  int vec = 0;
  int miscmp = 0;

  assign rf_rdata = rf[rf_raddr];

  always #5 clk = ~clk;

  pipe_reg_checkpoint dut (
    .clk(clk), .rst(rst), .start(start), .check_cycle(check_cycle),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_valid(exp_valid),
    .exp_reg(exp_reg), .exp_val(exp_val),
`ifdef PC_CHECK_EN
    .pc(pc), .exp_pc(exp_pc),
`endif
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .cycle(cycle),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .fail_idx(fail_idx), .fail_data(fail_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vec++;
    assert (obs === expv) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input int idx, input logic v, input int r, input int val);
    exp_we = 1'b1; exp_idx = 3'(idx); exp_valid = v; exp_reg = 5'(r); exp_val = 32'(val);
    tick();
    exp_we = 1'b0;
  endtask

  task automatic load_table();
    wr(0, 1'b1, 23, 20);
    wr(1, 1'b1, 24, 35);
    wr(2, 1'b1, 8, 70);
    wr(3, 1'b1, 17, 1);
    for (int i = 4; i < 8; i++) wr(i, 1'b0, 0, 0);
  endtask

  task automatic good_rf();
    rf[23] = 32'd20; rf[24] = 32'd35; rf[8] = 32'd70; rf[17] = 32'd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_cycle"}, cycle, 0);
    chk({tag, "_raddr"}, rf_raddr, 0);
    chk({tag, "_mcnt"}, mismatch_cnt, 0);
    chk({tag, "_fidx"}, fail_idx, 0);
    chk({tag, "_fdata"}, fail_data, 0);
  endtask

  // Starts a run and follows it through nscan SCAN cycles; nscan==8 ends in DONE.
  task automatic run(input int cc, input int nscan);
    int ce;
    ce = (cc == 0) ? 1 : cc;
    check_cycle = 32'(cc); start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_cycle1", cycle, 1);
    chk("run_done_low", done, 0);
    repeat (ce - 1) tick();
    chk("ckpt_cycle", cycle, 64'(ce));
    chk("ckpt_raddr", rf_raddr, 0);
    for (int i = 0; i < nscan; i++) begin
      tick();
      chk("scan_raddr", rf_raddr, seq[i]);
      chk("scan_cycle_hold", cycle, 64'(ce));
      chk("scan_done_low", done, 0);
    end
    if (nscan == 8) begin
      tick();
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_raddr", rf_raddr, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    seq = '{5'd23, 5'd24, 5'd8, 5'd17, 5'd0, 5'd0, 5'd0, 5'd0};
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Clean run with checkpoint 24.
    load_table();
    good_rf();
    run(24, 8);
    chk("t1_pass", pass, 1);
    chk("t1_mcnt", mismatch_cnt, 0);
    chk("t1_fidx", fail_idx, 0);

    // Two corrupted registers, restarted from DONE with the table retained.
    rf[8] = 32'd69; rf[17] = 32'd0;
    run(24, 8);
    chk("t2_pass", pass, 0);
    chk("t2_mcnt", mismatch_cnt, 2);
    chk("t2_fidx", fail_idx, 2);
    chk("t2_fdata", fail_data, 69);
    tick();
    chk("t2_held_mcnt", mismatch_cnt, 2);

    // Fresh counters on the next run.
    good_rf();
    run(0, 8);
    chk("t3_pass", pass, 1);
    chk("t3_mcnt", mismatch_cnt, 0);
    chk("t3_fdata", fail_data, 0);
    run(5, 8);
    chk("t3b_pass", pass, 1);

    // exp_we and start during COUNT must be ignored.
    check_cycle = 32'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    exp_we = 1'b1; exp_idx = 3'd0; exp_valid = 1'b1; exp_reg = 5'd5; exp_val = 32'd99;
    start = 1'b1; check_cycle = 32'd3;
    tick();
    exp_we = 1'b0; start = 1'b0;
    chk("t4_no_restart", cycle, 4);
    chk("t4_busy", busy, 1);
    repeat (6) tick();
    chk("t4_ckpt_cycle", cycle, 10);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_scan_raddr", rf_raddr, seq[i]);
    end
    tick();
    chk("t4_done", done, 1);
    chk("t4_pass", pass, 1);

    // Reset in the third SCAN cycle after a mismatch at entry 1.
    rf[24] = 32'd34;
    run(4, 3);
    chk("t5_pre_mcnt", mismatch_cnt, 1);
    chk("t5_pre_fidx", fail_idx, 1);
    chk("t5_pre_fdata", fail_data, 34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midscan_rst");
    // Table must now be all-invalid: every scan address is 0 and nothing fails.
    seq = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    run(2, 8);
    chk("t5_cleared_pass", pass, 1);
    seq = '{5'd23, 5'd24, 5'd8, 5'd17, 5'd0, 5'd0, 5'd0, 5'd0};
    load_table();
    good_rf();
    run(3, 8);
    chk("t5_reload_pass", pass, 1);
    chk("t5_reload_mcnt", mismatch_cnt, 0);

`ifdef PC_CHECK_EN
    exp_pc = 32'd216; pc = 32'd220;
    run(6, 8);
    chk("pc_mcnt", mismatch_cnt, 1);
    chk("pc_fidx", fail_idx, 8);
    chk("pc_fdata", fail_data, 220);
    chk("pc_pass", pass, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
